// File: rtl/cdc_gray_src_chan.sv
// Source half of a gray-pointer CDC FIFO for one AXI channel, with an
// isolate/drain handshake for quiescing before a power or clock switch.
module cdc_gray_src_chan #(
    parameter int DATA_WIDTH  = 64,
    parameter int LOG_DEPTH   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 src_valid_i,
    output logic                                 src_ready_o,
    input  logic [DATA_WIDTH-1:0]                src_data_i,
    input  logic                                 isolate_req_i,
    output logic                                 isolated_o,
    output logic [LOG_DEPTH:0]                   fill_o,
    output logic [LOG_DEPTH:0]                   async_wptr_o,
    output logic [(2**LOG_DEPTH)*DATA_WIDTH-1:0] async_data_o,
    input  logic [LOG_DEPTH:0]                   async_rptr_i
);
    localparam int DEPTH = 2**LOG_DEPTH;
    localparam int PW    = LOG_DEPTH + 1;

    typedef enum logic [1:0] {RUN, DRAIN, ISOLATED} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] wptr_bin, wptr_nxt;
    logic [PW-1:0] rptr_sync [SYNC_STAGES];
    logic [PW-1:0] rptr_sync_gray, rptr_bin;
    logic [PW-1:0] fill;
    logic          full, write;

    assign rptr_sync_gray = rptr_sync[SYNC_STAGES-1];

    always_comb begin
        rptr_bin = '0;
        for (int i = 0; i < PW; i++)
            rptr_bin[i] = ^(rptr_sync_gray >> i);
    end

    // Full is judged against a stale read pointer, so it can only err towards full.
    assign fill        = wptr_bin - rptr_bin;
    assign full        = (fill == PW'(DEPTH));
    assign src_ready_o = !rst_i && (state == RUN) && !full;
    assign write       = src_valid_i && src_ready_o;
    assign wptr_nxt    = wptr_bin + PW'(1);
    assign isolated_o  = (state == ISOLATED);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                rptr_sync[i] <= '0;
        end else begin
            rptr_sync[0] <= async_rptr_i;
            for (int i = 1; i < SYNC_STAGES; i++)
                rptr_sync[i] <= rptr_sync[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_bin     <= '0;
            async_wptr_o <= '0;
            fill_o       <= '0;
            state        <= RUN;
        end else begin
            if (write) begin
                wptr_bin     <= wptr_nxt;
                async_wptr_o <= wptr_nxt ^ (wptr_nxt >> 1);
            end
            fill_o <= fill;
            state  <= state_nxt;
        end
    end

    // Slot and pointer update on the same edge, so data never trails its pointer.
    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (rst_i)
                async_data_o[s*DATA_WIDTH +: DATA_WIDTH] <= '0;
            else if (write && wptr_bin[LOG_DEPTH-1:0] == LOG_DEPTH'(s))
                async_data_o[s*DATA_WIDTH +: DATA_WIDTH] <= src_data_i;
        end
    end

    // Drain exits only once both the registered and the live fill read empty,
    // which covers a word accepted in the cycle the request arrived.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (isolate_req_i) state_nxt = DRAIN;
            DRAIN:    if (fill_o == '0 && fill == '0) state_nxt = ISOLATED;
            ISOLATED: if (!isolate_req_i) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_cdc_gray_src_chan.sv
// Bench for cdc_gray_src_chan: directed handshake/isolate cases on a depth-2
// instance, random streaming into a depth-4 instance against a queue-based sink.
module tb_cdc_gray_src_chan;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          v1, r1, iso1, isod1;
    logic [W-1:0]  d1;
    logic [1:0]    fill1, wp1, rp1;
    logic [2*W-1:0] ad1;

    logic          v2, r2, iso2, isod2;
    logic [W-1:0]  d2;
    logic [2:0]    fill2, wp2, rp2;
    logic [4*W-1:0] ad2;

    cdc_gray_src_chan #(.DATA_WIDTH(W), .LOG_DEPTH(1), .SYNC_STAGES(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .src_valid_i(v1), .src_ready_o(r1), .src_data_i(d1),
        .isolate_req_i(iso1), .isolated_o(isod1), .fill_o(fill1), .async_wptr_o(wp1),
        .async_data_o(ad1), .async_rptr_i(rp1));

    cdc_gray_src_chan #(.DATA_WIDTH(W), .LOG_DEPTH(2), .SYNC_STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .src_valid_i(v2), .src_ready_o(r2), .src_data_i(d2),
        .isolate_req_i(iso2), .isolated_o(isod2), .fill_o(fill2), .async_wptr_o(wp2),
        .async_data_o(ad2), .async_rptr_i(rp2));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Gray decode by definition: find the binary value whose gray code matches.
    function automatic logic [2:0] g2b(input logic [2:0] g);
        for (int v = 0; v < 8; v++)
            if (3'(v ^ (v >> 1)) == g) return 3'(v);
        return 3'd0;
    endfunction

    // Sink model for dut2: sees the write pointer 4 cycles late, pops every
    // newly visible slot against the queue of accepted words, then acks.
    logic [W-1:0] q[$];
    logic [2:0]   dly [4] = '{default: 3'd0};
    logic [2:0]   rd_bin = 3'd0;
    logic [2:0]   prev_wp = 3'd0;
    logic [2:0]   seen_bin;
    int           rx_cnt = 0;

    initial rp2 = 3'd0;

    always @(negedge clk) begin
        seen_bin = g2b(dly[3]);
        dly[3] = dly[2];
        dly[2] = dly[1];
        dly[1] = dly[0];
        dly[0] = wp2;
        while (rd_bin != seen_bin) begin
            chk("rx_data", 64'(ad2[int'(rd_bin[1:0])*W +: W]),
                (q.size() != 0) ? 64'(q.pop_front()) : 64'hDEAD_BEEF_DEAD_BEEF);
            rd_bin = rd_bin + 3'd1;
            rx_cnt++;
        end
        rp2 = rd_bin ^ (rd_bin >> 1);
        if (wp2 != prev_wp) chk("wptr_one_bit", 64'($countones(wp2 ^ prev_wp)), 1);
        prev_wp = wp2;
        if (fill2 > 3'd4) chk("fill_bound", 64'(fill2), 4);
    end

    int k;
    int sent;
    bit rdy_seen;

    initial begin
        v1 = 0; d1 = '0; iso1 = 0; rp1 = 2'b00;
        v2 = 0; d2 = '0; iso2 = 0;

        // reset with valid held high
        rst = 1; v1 = 1;
        repeat (3) begin @(negedge clk); chk("rst_ready", r1, 0); end
        chk("rst_wptr", wp1, 0);
        chk("rst_isolated", isod1, 0);
        chk("rst_fill", fill1, 0);
        chk("rst_data", ad1, 0);
        rst = 0; v1 = 0;
        #1 chk("ready_after_rst", r1, 1);

        // fill a depth-2 FIFO with the sink frozen
        v1 = 1; d1 = 16'hA0A0;
        @(negedge clk);
        chk("wptr_after_A", wp1, 2'b01);
        chk("slot0_A", ad1[W-1:0], 16'hA0A0);
        chk("ready_after_A", r1, 1);
        d1 = 16'hB1B1;
        @(negedge clk);
        chk("wptr_after_B", wp1, 2'b11);
        chk("slot1_B", ad1[2*W-1:W], 16'hB1B1);
        chk("ready_full", r1, 0);
        v1 = 0;
        @(negedge clk);
        chk("fill_full", fill1, 2);

        // sink acks one word; ready returns after the synchroniser
        rp1 = 2'b01;
        @(negedge clk); chk("ready_sync_hold", r1, 0);
        @(negedge clk); chk("ready_released", r1, 1);
        @(negedge clk); chk("fill_after_ack", fill1, 1);

        // isolate with two words outstanding
        v1 = 1; d1 = 16'hC2C2;
        @(negedge clk);
        v1 = 0;
        chk("ready_full2", r1, 0);
        chk("slot0_C", ad1[W-1:0], 16'hC2C2);
        @(negedge clk); chk("fill_two", fill1, 2);
        iso1 = 1;
        @(negedge clk);
        iso1 = 0;
        chk("drain_ready", r1, 0);
        chk("drain_not_isolated", isod1, 0);
        rp1 = 2'b10;
        k = 0; rdy_seen = 0;
        while (!isod1 && k < 12) begin @(negedge clk); k++; if (r1) rdy_seen = 1; end
        chk("drain_done", isod1, 1);
        chk("drain_ready_low", rdy_seen, 0);
        chk("isolated_ready", r1, 0);
        @(negedge clk);
        chk("resume_run", isod1, 0);
        chk("resume_ready", r1, 1);

        // isolate request in the same cycle as a write
        v1 = 1; d1 = 16'hD3D3; iso1 = 1;
        @(negedge clk);
        v1 = 0; iso1 = 0;
        chk("iso_wr_ready", r1, 0);
        chk("iso_wr_slot1", ad1[2*W-1:W], 16'hD3D3);
        chk("iso_wr_wptr_wrap", wp1, 2'b00);
        @(negedge clk); chk("iso_wr_fill", fill1, 1);
        repeat (4) @(negedge clk);
        chk("iso_wr_waits", isod1, 0);
        rp1 = 2'b00;
        k = 0;
        while (!isod1 && k < 12) begin @(negedge clk); k++; end
        chk("iso_wr_drain_done", isod1, 1);
        @(negedge clk);
        chk("iso_wr_resume", isod1, 0);

        // reset while draining
        v1 = 1; d1 = 16'hE4E4; iso1 = 1;
        @(negedge clk);
        v1 = 0; iso1 = 0;
        chk("rd_in_drain", r1, 0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rd_ready_run", r1, 1);
        chk("rd_fill", fill1, 0);
        chk("rd_isolated", isod1, 0);
        chk("rd_wptr", wp1, 0);

        // random stream of 20 words into the depth-4 instance
        sent = 0; k = 0;
        while (sent < 20 && k < 2000) begin
            @(negedge clk); k++;
            v2 = ($urandom_range(0, 3) != 0);
            d2 = W'($urandom);
            if (v2 && r2) begin q.push_back(d2); sent++; end
        end
        @(negedge clk);
        v2 = 0;
        chk("tx_count", sent, 20);
        k = 0;
        while (rx_cnt < 20 && k < 500) begin @(negedge clk); k++; end
        chk("rx_count", rx_cnt, 20);
        chk("rx_queue_empty", q.size(), 0);
        chk("wptr_final", wp2, 3'b110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
